// File: rtl/apb_pkg.sv
// apb_pkg
// Shared definitions for the APB master bridge: FSM state encoding,
// default bus widths and the strobe-width helper.
package apb_pkg;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    // One strobe bit per data byte.
    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
// Counts ACCESS cycles spent waiting on pready so the bridge can abort a
// transfer to a slave that never answers.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   clr                : restart the count (asserted while entering ACCESS)
//   inc                : one more wait cycle seen
//   expire             : count has reached TIMEOUT_CYCLES-1
module apb_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    assign expire = (count == CNT_W'(TIMEOUT_CYCLES - 1));

    // Saturates at the terminal value; the bridge leaves ACCESS on expiry
    // so the count never needs to wrap.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !expire) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge
// Turns a valid/ready register-request stream into single APB4 transfers on
// the timer slave port and returns each result on a valid/ready response
// channel. One transfer in flight at a time.
//
// Optional feature macro: APB_TIMEOUT_EN
//   defined   : ACCESS is aborted after TIMEOUT_CYCLES cycles without pready,
//               answered with rsp_err=1, rsp_timeout=1, rsp_rdata=0
//   undefined : ACCESS waits indefinitely, rsp_timeout is constant 0
//
// Ports:
//   sys_clk, sys_rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready         : request handshake (ready only in IDLE)
//   req_write/addr/wdata/strb   : request fields
//   rsp_valid/rsp_ready         : response handshake
//   rsp_rdata/rsp_err/timeout   : response fields, held until consumed
//   tim_p*                      : APB4 master port to timer_top
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request; req_ready=1
// SETUP | APB setup phase, psel=1 penable=0
// ACCESS| APB access phase, psel=1 penable=1, waiting on pready
// RESP  | response presented, waiting for rsp_ready
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,

    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_write,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [strb_width(DATA_W)-1:0] req_strb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err,
    output logic                          rsp_timeout,

    output logic                          tim_psel,
    output logic                          tim_penable,
    output logic                          tim_pwrite,
    output logic [ADDR_W-1:0]             tim_paddr,
    output logic [DATA_W-1:0]             tim_pwdata,
    output logic [strb_width(DATA_W)-1:0] tim_pstrb,
    input  logic [DATA_W-1:0]             tim_prdata,
    input  logic                          tim_pready,
    input  logic                          tim_pslverr
);

    apb_state_t state;
    logic       timeout_hit;

    assign req_ready = (state == IDLE);

`ifdef APB_TIMEOUT_EN
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_expire;
    logic rsp_timeout_q;

    assign cnt_clr     = (state == SETUP);
    assign cnt_inc     = (state == ACCESS) && !tim_pready;
    // pready in the same cycle wins, so expiry only counts on a wait cycle.
    assign timeout_hit = cnt_inc && cnt_expire;
    assign rsp_timeout = rsp_timeout_q;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (cnt_clr),
        .inc       (cnt_inc),
        .expire    (cnt_expire)
    );
`else
    logic unused_timeout_cycles;

    assign timeout_hit           = 1'b0;
    assign rsp_timeout           = 1'b0;
    // TIMEOUT_CYCLES only matters when the abort counter is built.
    assign unused_timeout_cycles = (TIMEOUT_CYCLES > 0);
`endif

    // The APB address/control/data registers double as the request capture:
    // they are loaded on acceptance and simply hold afterwards, which keeps
    // them stable through SETUP/ACCESS and leaves the last value in IDLE/RESP.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            tim_psel    <= 1'b0;
            tim_penable <= 1'b0;
            tim_pwrite  <= 1'b0;
            tim_paddr   <= '0;
            tim_pwdata  <= '0;
            tim_pstrb   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
`ifdef APB_TIMEOUT_EN
            rsp_timeout_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        tim_pwrite  <= req_write;
                        tim_paddr   <= req_addr;
                        // APB4: reads carry no write data and no strobes.
                        tim_pwdata  <= req_write ? req_wdata : '0;
                        tim_pstrb   <= req_write ? req_strb  : '0;
                        tim_psel    <= 1'b1;
                        tim_penable <= 1'b0;
                        state       <= SETUP;
                    end
                end

                SETUP: begin
                    tim_penable <= 1'b1;
                    state       <= ACCESS;
                end

                ACCESS: begin
                    if (tim_pready) begin
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= tim_pwrite ? '0 : tim_prdata;
                        rsp_err     <= tim_pslverr;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_q <= 1'b0;
`endif
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        tim_psel    <= 1'b0;
                        tim_penable <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
`ifdef APB_TIMEOUT_EN
                        rsp_timeout_q <= 1'b1;
`endif
                        state       <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
module tb_apb_master_bridge;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int TO_CYC = 16;

    logic              sys_clk   = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic [STRB_W-1:0] req_strb  = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b1;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;
    logic              tim_psel;
    logic              tim_penable;
    logic              tim_pwrite;
    logic [ADDR_W-1:0] tim_paddr;
    logic [DATA_W-1:0] tim_pwdata;
    logic [STRB_W-1:0] tim_pstrb;
    logic [DATA_W-1:0] tim_prdata;
    logic              tim_pready;
    logic              tim_pslverr;

    always #5 sys_clk = ~sys_clk;

    apb_master_bridge #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TO_CYC)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .tim_psel    (tim_psel),
        .tim_penable (tim_penable),
        .tim_pwrite  (tim_pwrite),
        .tim_paddr   (tim_paddr),
        .tim_pwdata  (tim_pwdata),
        .tim_pstrb   (tim_pstrb),
        .tim_prdata  (tim_prdata),
        .tim_pready  (tim_pready),
        .tim_pslverr (tim_pslverr)
    );

    // ---------------- slave model ----------------
    logic        slv_stuck = 1'b0;
    int          slv_wait  = 0;
    logic [31:0] slv_rdata = 32'h0;
    logic        slv_err   = 1'b0;
    int          acc_cnt;

    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) acc_cnt <= 0;
        else if (tim_psel && tim_penable && !tim_pready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    assign tim_pready  = !slv_stuck && (acc_cnt == slv_wait);
    assign tim_prdata  = slv_rdata;
    assign tim_pslverr = slv_err && tim_pready;

    // ---------------- scoreboard ----------------
    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          access;
    } exp_t;

    exp_t sb_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input string name, input logic [31:0] rd, input logic err,
                            input logic to, input int access);
        exp_t e;
        e.name = name; e.rdata = rd; e.err = err; e.to = to; e.access = access;
        sb_q.push_back(e);
    endtask

    // expected APB fields of the transfer currently on the bus
    logic        bx_write = 1'b0;
    logic [11:0] bx_addr  = '0;
    logic [31:0] bx_wdata = '0;
    logic [3:0]  bx_strb  = '0;

    int   cyc = 0;
    int   psel_cnt = 0, pen_cnt = 0, acc_cyc = 0, val_cyc = 0;
    logic bus_bad = 1'b0, prev_valid = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        exp_t e;
        if (!sys_rst_n) begin
            psel_cnt = 0; pen_cnt = 0; bus_bad = 1'b0; prev_valid = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                acc_cyc = cyc; psel_cnt = 0; pen_cnt = 0; bus_bad = 1'b0;
            end
            if (tim_psel) begin
                psel_cnt++;
                if (tim_pwrite !== bx_write || tim_paddr !== bx_addr ||
                    tim_pwdata !== bx_wdata || tim_pstrb !== bx_strb)
                    bus_bad = 1'b1;
            end
            if (tim_penable) begin
                pen_cnt++;
                if (!tim_psel) bus_bad = 1'b1;
            end
            if (rsp_valid && !prev_valid) val_cyc = cyc;
            prev_valid = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no_response");
                end else begin
                    e = sb_q.pop_front();
                    chk({e.name, "_rdata"},   rsp_rdata, e.rdata);
                    chk({e.name, "_err"},     32'(rsp_err), 32'(e.err));
                    chk({e.name, "_timeout"}, 32'(rsp_timeout), 32'(e.to));
                    chk({e.name, "_penable_cycles"}, 32'(pen_cnt), 32'(e.access));
                    chk({e.name, "_psel_cycles"},    32'(psel_cnt), 32'(e.access + 1));
                    chk({e.name, "_latency"},        32'(val_cyc - acc_cyc), 32'(e.access + 2));
                    chk({e.name, "_bus_stable"},     32'(bus_bad), 32'h0);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive_req(input logic w, input logic [11:0] a, input logic [31:0] d,
                             input logic [3:0] s);
        req_write = w; req_addr = a; req_wdata = d; req_strb = s; req_valid = 1'b1;
        bx_write = w; bx_addr = a; bx_wdata = w ? d : 32'h0; bx_strb = w ? s : 4'h0;
    endtask

    task automatic send(input string name, input logic w, input logic [11:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int waits,
                        input logic [31:0] srd, input logic serr, input logic stuck,
                        input logic [31:0] erd, input logic eerr, input logic eto,
                        input int access, input bit expect_rsp);
        bit ok = 1'b0;
        @(posedge sys_clk); #1;
        slv_wait = waits; slv_rdata = srd; slv_err = serr; slv_stuck = stuck;
        drive_req(w, a, d, s);
        for (int i = 0; i < 50; i++) begin
            @(negedge sys_clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL %s_accept actual=not_accepted required=accepted", name);
        end else if (expect_rsp) begin
            push_exp(name, erd, eerr, eto, access);
        end
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (sb_q.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL %s_response actual=missing required=response", name);
            sb_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        // reset state
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_psel",      32'(tim_psel), 32'h0);
        chk("rst_penable",   32'(tim_penable), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_paddr",     32'(tim_paddr), 32'h0);
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;

        // name                 w     addr    wdata         strb wt srd           serr  stuck erd           eerr  eto   acc rsp
        send("wr0",        1'b1, 12'h000, 32'h0000_0001, 4'hF, 0, 32'hDEAD_0000, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1, 1);
        wait_idle("wr0");
        send("rd4",        1'b0, 12'h004, 32'hFFFF_FFFF, 4'hF, 2, 32'h1234_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0, 1'b0, 3, 1);
        wait_idle("rd4");
        send("wr_ffc_err", 1'b1, 12'hFFC, 32'hA5A5_A5A5, 4'h3, 0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1, 1);
        wait_idle("wr_ffc_err");
        send("rd10",       1'b0, 12'h010, 32'h0,         4'h0, 0, 32'h0BAD_BEEF, 1'b0, 1'b0, 32'h0BAD_BEEF, 1'b0, 1'b0, 1, 1);
        wait_idle("rd10");
        send("rd_c_err",   1'b0, 12'h00C, 32'h0,         4'h0, 1, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2, 1);
        wait_idle("rd_c_err");

        // response back-pressure with a second request waiting
        @(posedge sys_clk); #1 rsp_ready = 1'b0;
        send("hold_rd8",   1'b0, 12'h008, 32'h0,         4'h0, 0, 32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1, 1);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) begin seen = 1'b1; break; end
        end
        chk("hold_rsp_seen", 32'(seen), 32'h1);
        @(posedge sys_clk); #1;
        slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'h7777_7777;
        drive_req(1'b1, 12'h020, 32'h0000_0055, 4'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge sys_clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
            chk("hold_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
            chk("hold_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge sys_clk); #1 rsp_ready = 1'b1;
        @(negedge sys_clk);
        chk("hold_req_ready_hs_cycle", 32'(req_ready), 32'h0);
        @(negedge sys_clk);
        chk("hold_req_ready_after", 32'(req_ready), 32'h1);
        if (req_ready) push_exp("hold_wr20", 32'h0, 1'b0, 1'b0, 1);
        @(posedge sys_clk); #1 req_valid = 1'b0;
        wait_idle("hold_wr20");

`ifdef APB_TIMEOUT_EN
        send("timeout",    1'b0, 12'h050, 32'h0,         4'h0, 0, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0,        1'b1, 1'b1, TO_CYC, 1);
        wait_idle("timeout");
`endif

        // reset during ACCESS: transfer dropped without a response
        send("rst_xfer",   1'b0, 12'h040, 32'h0,         4'h0, 0, 32'h1111_1111, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 1, 0);
`ifdef APB_TIMEOUT_EN
        repeat (5) @(negedge sys_clk);
`else
        repeat (120) @(negedge sys_clk);
        chk("stuck_psel_100plus", 32'(psel_cnt >= 100), 32'h1);
`endif
        chk("stuck_psel",    32'(tim_psel), 32'h1);
        chk("stuck_penable", 32'(tim_penable), 32'h1);
        @(posedge sys_clk); #3 sys_rst_n = 1'b0;
        #1;
        chk("arst_psel",      32'(tim_psel), 32'h0);
        chk("arst_penable",   32'(tim_penable), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h1);
        chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
        slv_stuck = 1'b0;
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (rsp_valid) seen = 1'b1;
        end
        chk("arst_no_rsp", 32'(seen), 32'h0);
        chk("arst_req_ready_after", 32'(req_ready), 32'h1);

        send("post_rst_wr30", 1'b1, 12'h030, 32'h0000_1234, 4'hF, 1, 32'h0,   1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 2, 1);
        wait_idle("post_rst_wr30");

        repeat (3) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
Converts a simple valid/ready register-request stream into APB4 transfers that drive the timer_top slave port (tim_* signals). Sits directly upstream of the timer. It replaces hand-written bus tasks with a synthesizable master, which can be reused by an on-chip sequencer or by the bench. One transfer is in flight at a time, and the response is returned on a valid/ready channel.

Parameters:
ADDR_W, 12, APB address width (matches tim_paddr)
DATA_W, 32, APB data width; strobe width is DATA_W/8
TIMEOUT_CYCLES, 16, max ACCESS cycles without pready before abort (used only with APB_TIMEOUT_EN)

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready
req_write  input  1  1=write, 0=read
req_addr  input  ADDR_W  target address
req_wdata  input  DATA_W  write data
req_strb  input  DATA_W/8  byte strobes for writes
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when valid&ready
rsp_rdata  output  DATA_W  read data (0 for writes)
rsp_err  output  1  pslverr or timeout
rsp_timeout  output  1  transfer aborted by timeout
tim_psel  output  1  APB select
tim_penable  output  1  APB enable
tim_pwrite  output  1  APB direction
tim_paddr  output  ADDR_W  APB address
tim_pwdata  output  DATA_W  APB write data
tim_pstrb  output  DATA_W/8  APB strobes
tim_prdata  input  DATA_W  APB read data
tim_pready  input  1  APB ready / wait-state
tim_pslverr  input  1  APB error

Behaviour:
- Reset is asynchronous. In reset: state=IDLE; all APB outputs, rsp_* and the captured registers are 0. req_ready=(state==IDLE), so it reads 1 during and after reset.
- FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE: on req_valid&req_ready, capture write/addr/wdata/strb and go to SETUP. For a read, captured wdata=0 and strb=0 (APB4 rule).
- SETUP (1 cycle): psel=1, penable=0, and paddr/pwrite/pwdata/pstrb take the captured values. Go to ACCESS.
- ACCESS: psel=1, penable=1. Address, control and data stay stable.
  - pready=0: stay in ACCESS (wait state).
  - pready=1: latch rsp_rdata = write ? 0 : prdata, and rsp_err = pslverr. Go to RESP. psel and penable are 0 on the next cycle.
- RESP: rsp_valid=1, with rsp_rdata/rsp_err/rsp_timeout held stable. On rsp_ready, go to IDLE, clear rsp_valid and hold the data values.
  - req_ready=0 in every state except IDLE.
- Latency with zero wait states: accept edge -> SETUP -> ACCESS -> rsp_valid on the 3rd cycle after acceptance. Minimum throughput is 4 cycles per transfer, assuming rsp_ready is already high.
- tim_paddr/pwdata/pstrb/pwrite keep their last value in IDLE/RESP. Only psel/penable return to 0.
- pslverr is sampled only in the ACCESS cycle where pready=1.
- Reset asserted mid-transfer: psel and penable drop immediately. The transfer is dropped with no response. After reset the FSM is in IDLE.
- req_valid is ignored outside IDLE. It must be held by the source until accepted.

Optional Feature:
APB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with pready=0.
  - When count==TIMEOUT_CYCLES-1 and pready=0, the transfer is aborted: psel and penable go to 0 the next cycle and the FSM goes to RESP.
  - The response is rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - pready=1 in the same cycle takes precedence, giving a normal completion.
- Undefined: no counter; ACCESS waits indefinitely; rsp_timeout is tied to 0.

Decomposition:
- Package apb_pkg:
  - FSM state enum (IDLE/SETUP/ACCESS/RESP)
  - default ADDR_W/DATA_W constants
  - strobe-width function
- One natural sub-module, apb_timeout_cnt: counter, clear, increment and expire output. Instantiated only under APB_TIMEOUT_EN.

Test Plan:
- Write 0x000 data 0x0000_0001 strb 0xF, pready=1, rsp_ready=1 -> psel high 2 cycles, penable high 1, pwrite=1, rsp_valid on 3rd cycle after accept, rsp_err=0, rsp_rdata=0.
- Read 0x004, slave inserts 2 wait states, then prdata=0x1234_5678 -> penable high 3 cycles, paddr stable throughout, pstrb=0, rsp_rdata=0x1234_5678.
- Write 0xFFC with pslverr=1 on the completing cycle -> rsp_err=1, rsp_timeout=0; the next request is accepted normally.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_valid and data hold, req_ready=0; a req_valid presented meanwhile is not accepted until 1 cycle after rsp_ready.
- With APB_TIMEOUT_EN, TIMEOUT_CYCLES=16, pready stuck 0 -> exactly 16 ACCESS cycles, then psel=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0. Without the macro, psel stays high for 100+ cycles.
- sys_rst_n pulled low during ACCESS -> psel/penable=0 asynchronously, no rsp_valid, req_ready=1 after release.
